// File: rtl/async_rd_ctrl_fwft.sv
// async_rd_ctrl_fwft: read-domain controller for the dual-clock FIFO.
// Holds the binary/gray read pointer, derives empty/count from the
// synchronised write pointer and drives a registered-output RAM.
// Optional feature macro: ASYNC_RD_CTRL_FWFT_EN selects a first-word-fall-through
// output stage (two-entry buffer plus one in-flight RAM read).
module async_rd_ctrl_fwft #(
    parameter int DEPTH             = 4,
    parameter int DWIDTH            = 32,
    parameter int PROG_EMPTY_THRESH = 1
) (
    input  logic                       rd_clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH):0]     wr_ptr_rsync,
    input  logic [DWIDTH-1:0]          mem_rd_data,
    output logic                       mem_rd_en,
    output logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [$clog2(DEPTH):0]     rd_ptr,
    output logic [DWIDTH-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       rd_empty,
    output logic                       rd_prog_empty,
    output logic [$clog2(DEPTH):0]     rd_count,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PE_THRESH = (AW+1)'(PROG_EMPTY_THRESH);

    logic [AW:0] rd_bin;
    logic [AW:0] rd_bin_next;
    logic [AW:0] wr_bin;
    logic [AW:0] ram_count;
    logic        ram_empty;
    logic        issue;

    // Gray-to-binary conversion of the synchronised write pointer.
    always_comb begin
        wr_bin = '0;
        for (int unsigned i = 0; i <= AW; i++) begin
            wr_bin[i] = ^(wr_ptr_rsync >> i);
        end
    end

    // RAM occupancy as seen from the read side; wraps modulo 2^(AW+1).
    always_comb begin
        ram_empty   = (rd_bin == wr_bin);
        ram_count   = wr_bin - rd_bin;
        rd_bin_next = rd_bin + (AW+1)'(issue);
    end

    // Read pointer register: binary counter and its gray copy move together.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            rd_bin <= '0;
            rd_ptr <= '0;
        end else begin
            rd_bin <= rd_bin_next;
            rd_ptr <= rd_bin_next ^ (rd_bin_next >> 1);
        end
    end

    assign rd_addr   = rd_bin[AW-1:0];
    assign mem_rd_en = issue;

`ifdef ASYNC_RD_CTRL_FWFT_EN

    logic [1:0]        occ;
    logic [1:0]        occ_next;
    logic              inflight;
    logic              pop;
    logic [1:0]        held_after;
    logic [DWIDTH-1:0] buf0;
    logic [DWIDTH-1:0] buf1;
    logic [DWIDTH-1:0] buf0_next;
    logic [DWIDTH-1:0] buf1_next;

    // Prefetch decision: keep buffer plus in-flight read at no more than two words.
    always_comb begin
        pop        = rd_en & rd_valid;
        held_after = occ + 2'(inflight) - 2'(pop);
        issue      = ~ram_empty & (held_after < 2'd2);
    end

    // Buffer update: pop shifts the head out, then returning RAM data fills
    // the first free slot (slot index is the occupancy left after the pop).
    always_comb begin
        buf0_next = buf0;
        buf1_next = buf1;
        occ_next  = occ;
        if (pop) begin
            buf0_next = buf1;
            occ_next  = occ - 2'd1;
        end
        if (inflight) begin
            if (occ_next == 2'd0) begin
                buf0_next = mem_rd_data;
            end else begin
                buf1_next = mem_rd_data;
            end
            occ_next = occ_next + 2'd1;
        end
    end

    // Output stage registers, in-flight flag and underflow pulse.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            occ       <= '0;
            inflight  <= 1'b0;
            buf0      <= '0;
            buf1      <= '0;
            underflow <= 1'b0;
        end else begin
            occ       <= occ_next;
            inflight  <= issue;
            buf0      <= buf0_next;
            buf1      <= buf1_next;
            underflow <= rd_en & ~rd_valid;
        end
    end

    // Visible outputs: head of buffer and total words owned by the read side.
    always_comb begin
        rd_data  = buf0;
        rd_valid = (occ != 2'd0);
        rd_empty = ~rd_valid;
        rd_count = ram_count + (AW+1)'(inflight) + (AW+1)'(occ);
    end

    // Buffer occupancy plus the outstanding read never exceeds two entries.
    a_hold_bound: assert property (@(posedge rd_clk) disable iff (rst)
        ((3'(occ) + 3'(inflight)) <= 3'd2));

`else

    // Plain read request: issue straight from rd_en when the RAM has data.
    always_comb begin
        issue = rd_en & ~ram_empty;
    end

    // Data-valid tracks the RAM read latency; underflow flags a refused pop.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid  <= issue;
            underflow <= rd_en & rd_empty;
        end
    end

    // Outputs pass straight through from the RAM and the pointer compare.
    always_comb begin
        rd_data  = mem_rd_data;
        rd_empty = ram_empty;
        rd_count = ram_count;
    end

`endif

    // Programmable-empty threshold on the reported fill count.
    always_comb begin
        rd_prog_empty = (rd_count <= PE_THRESH);
    end

endmodule

// File: tb/tb_async_rd_ctrl_fwft.sv
// Testbench for async_rd_ctrl_fwft: directed stimulus, count-based reference
// model and a per-cycle compare process, plus literal spot checks.
module tb_async_rd_ctrl_fwft;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DW    = 16;
    localparam int PE    = 2;

`ifdef ASYNC_RD_CTRL_FWFT_EN
    localparam logic [AW:0] PTR_AFTER_FIRST = 3'b110;  // gray(4)
`else
    localparam logic [AW:0] PTR_AFTER_FIRST = 3'b010;  // gray(3)
`endif

    logic          rd_clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic [AW:0]   wr_ptr_rsync;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_en;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_empty;
    logic          rd_prog_empty;
    logic [AW:0]   rd_count;
    logic          underflow;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          chk_on = 1'b0;

    // Model state: words written, popped and fetched from RAM (never wrap).
    int            m_wr = 0;
    int            m_pop = 0;
    int            m_iss = 0;
    bit            m_infl = 1'b0;
    bit            e_valid = 1'b0;
    bit            e_under = 1'b0;
    logic [DW-1:0] e_data = '0;

    logic [DW-1:0] ram [DEPTH];
    logic [AW:0]   ptr_prev = '0;

    always #5 rd_clk = ~rd_clk;

    async_rd_ctrl_fwft #(
        .DEPTH(DEPTH),
        .DWIDTH(DW),
        .PROG_EMPTY_THRESH(PE)
    ) dut (
        .rd_clk(rd_clk),
        .rst(rst),
        .rd_en(rd_en),
        .wr_ptr_rsync(wr_ptr_rsync),
        .mem_rd_data(mem_rd_data),
        .mem_rd_en(mem_rd_en),
        .rd_addr(rd_addr),
        .rd_ptr(rd_ptr),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_empty(rd_empty),
        .rd_prog_empty(rd_prog_empty),
        .rd_count(rd_count),
        .underflow(underflow)
    );

    // Registered-output RAM behaviour.
    always @(posedge rd_clk) begin
        if (mem_rd_en) mem_rd_data <= ram[rd_addr];
    end

    function automatic logic [DW-1:0] word(input int k);
        return DW'(32'hA000 + k * 257);
    endfunction

    function automatic logic [AW:0] gray(input int v);
        logic [AW:0] b;
        b = (AW+1)'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            ram[m_wr % DEPTH] = word(m_wr);
            m_wr++;
        end
        wr_ptr_rsync = gray(m_wr);
    endtask

    // Reference model advance on each clock edge.
    int  u_vis;
    bit  u_pop;
    bit  u_iss;
    always @(posedge rd_clk) begin
        if (rst) begin
            m_pop   = 0;
            m_iss   = 0;
            m_infl  = 1'b0;
            e_valid = 1'b0;
            e_under = 1'b0;
        end else begin
`ifdef ASYNC_RD_CTRL_FWFT_EN
            u_vis   = m_iss - m_pop - int'(m_infl);
            u_pop   = rd_en && (u_vis > 0);
            e_under = rd_en && (u_vis == 0);
            u_iss   = (m_wr > m_iss) && ((m_iss - m_pop - int'(u_pop)) < 2);
            if (u_pop) m_pop++;
            if (u_iss) m_iss++;
            m_infl  = u_iss;
`else
            e_under = rd_en && (m_wr == m_pop);
            e_valid = rd_en && (m_wr > m_pop);
            if (e_valid) begin
                e_data = word(m_pop);
                m_pop++;
            end
            m_iss = m_pop;
`endif
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    int            c_cnt;
    int            c_vis;
    bit            c_valid;
    bit            c_mem;
    bit            c_empty;
    logic [DW-1:0] c_data;
    always @(negedge rd_clk) begin
        if (rst) begin
            ptr_prev = '0;
        end else if (chk_on) begin
            c_cnt = m_wr - m_pop;
`ifdef ASYNC_RD_CTRL_FWFT_EN
            c_vis   = m_iss - m_pop - int'(m_infl);
            c_valid = (c_vis > 0);
            c_mem   = (m_wr > m_iss) && ((m_iss - m_pop - int'(rd_en && c_valid)) < 2);
            c_data  = word(m_pop);
            c_empty = !c_valid;
`else
            c_valid = e_valid;
            c_mem   = rd_en && (c_cnt > 0);
            c_data  = e_data;
            c_empty = (c_cnt == 0);
`endif
            chk("mem_rd_en", mem_rd_en, c_mem);
            chk("rd_addr", rd_addr, m_iss % DEPTH);
            chk("rd_ptr", rd_ptr, gray(m_iss));
            chk("rd_count", rd_count, c_cnt);
            chk("rd_empty", rd_empty, c_empty);
            chk("rd_prog_empty", rd_prog_empty, c_cnt <= PE);
            chk("rd_valid", rd_valid, c_valid);
            chk("underflow", underflow, e_under);
            if (c_valid) chk("rd_data", rd_data, c_data);
            chk("ptr_one_bit", $countones(rd_ptr ^ ptr_prev) <= 1, 1);
            ptr_prev = rd_ptr;
        end
    end

    initial begin
        rst          = 1'b1;
        rd_en        = 1'b0;
        wr_ptr_rsync = '0;
        step();
        chk_on = 1'b1;
        step();
        rst = 1'b0;

        // Reset state.
        @(negedge rd_clk);
        chk("rst_empty", rd_empty, 1);
        chk("rst_count", rd_count, 0);
        chk("rst_prog_empty", rd_prog_empty, 1);
        chk("rst_ptr", rd_ptr, 0);
        chk("rst_underflow", underflow, 0);

`ifdef ASYNC_RD_CTRL_FWFT_EN
        // Four words appear; first word falls through two cycles later.
        step();
        push(4);
        @(negedge rd_clk);
        chk("fwft_valid_n0", rd_valid, 0);
        step();
        @(negedge rd_clk);
        chk("fwft_valid_n1", rd_valid, 0);
        step();
        @(negedge rd_clk);
        chk("fwft_valid_n2", rd_valid, 1);
        chk("fwft_data0", rd_data, 16'hA000);
        chk("fwft_count4", rd_count, 4);
        step();
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge rd_clk);
            chk("fwft_stream_valid", rd_valid, 1);
            chk("fwft_stream_data", rd_data, 32'hA000 + 257 * i);
            step();
        end
        rd_en = 1'b0;
        @(negedge rd_clk);
        chk("fwft_drained_empty", rd_empty, 1);
        chk("fwft_ptr", rd_ptr, PTR_AFTER_FIRST);
`else
        // Three words, three back-to-back reads at addresses 0,1,2.
        step();
        push(3);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge rd_clk);
            chk("std_addr", rd_addr, i);
            chk("std_mem_en", mem_rd_en, 1);
            step();
        end
        rd_en = 1'b0;
        @(negedge rd_clk);
        chk("std_last_valid", rd_valid, 1);
        chk("std_last_data", rd_data, 16'hA202);
        chk("std_ptr", rd_ptr, PTR_AFTER_FIRST);
        chk("std_empty", rd_empty, 1);
`endif

        // Pop while empty: one-cycle underflow, pointer untouched.
        step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        @(negedge rd_clk);
        chk("uf_pulse", underflow, 1);
        chk("uf_ptr", rd_ptr, PTR_AFTER_FIRST);
        step();
        @(negedge rd_clk);
        chk("uf_clear", underflow, 0);

        // Full FIFO, then drain across the programmable-empty threshold.
        step();
        push(4);
        step();
        step();
        step();
        @(negedge rd_clk);
        chk("full_count", rd_count, 4);
        chk("full_prog_empty", rd_prog_empty, 0);
        step();
        rd_en = 1'b1;
        step();
        @(negedge rd_clk);
        chk("pe_count3", rd_count, 3);
        chk("pe_at3", rd_prog_empty, 0);
        step();
        rd_en = 1'b0;
        @(negedge rd_clk);
        chk("pe_count2", rd_count, 2);
        chk("pe_at2", rd_prog_empty, 1);

        // Sustained traffic through many pointer wraps.
        step();
        for (int c = 0; c < 2000 && m_pop < 170; c++) begin
            rd_en = ((c % 5) != 3);
            if (((c % 3) != 1) && ((m_wr - m_pop) < DEPTH)) push(1);
            step();
        end
        chk("wrap_progress", m_pop >= 170, 1);

        // Mid-stream reset with words buffered and in flight.
        rd_en = 1'b1;
        if ((m_wr - m_pop) < DEPTH - 1) push(2);
        step();
        rst          = 1'b1;
        rd_en        = 1'b0;
        m_wr         = 0;
        wr_ptr_rsync = '0;
        step();
        rst = 1'b0;
        @(negedge rd_clk);
        chk("mrst_valid", rd_valid, 0);
        chk("mrst_underflow", underflow, 0);
        chk("mrst_empty", rd_empty, 1);
        chk("mrst_count", rd_count, 0);
        chk("mrst_ptr", rd_ptr, 0);
        chk("mrst_prog_empty", rd_prog_empty, 1);
`ifdef ASYNC_RD_CTRL_FWFT_EN
        chk("mrst_data", rd_data, 0);
`endif
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
